pid_err_diff: RTL and testbench

//  Front end of the incremental PID datapath. Takes unsigned setpoint/feedback

---
 rtl/pid_err_diff.sv | 93 +++++++++
 tb/tb_pid_err_diff.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pid_err_diff.sv
// Error / difference front end for the incremental PID datapath.
// Ports: clk, rst_n (sync, active-low), clr, in_valid/in_ready,
//   setpoint/feedback (W, unsigned), out_valid/out_ready,
//   e0 (W+1), d1 (W+2), d2 (W+3) signed, primed.
module pid_err_diff #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   setpoint,
    input  logic [W-1:0]   feedback,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W:0]     e0,
    output logic [W+1:0]   d1,
    output logic [W+2:0]   d2,
    output logic           primed
);

    // Stage 1 holds one raw error sample.
    logic         s1_valid;
    logic [W:0]   s1_e;

    // Error history e(k-1), e(k-2) and count of real samples in it.
    logic [W:0]   e1;
    logic [W:0]   e2;
    logic [1:0]   hist_cnt;

    logic         adv;
    logic         in_xfer;
    logic         flush;

    logic [W:0]   e_new;
    logic [W+1:0] d1_next;
    logic [W+2:0] d2_next;

    assign flush    = !rst_n || clr;
    assign adv      = s1_valid && (!out_valid || out_ready);
    assign in_ready = rst_n && !clr && (!s1_valid || adv);
    assign in_xfer  = in_valid && in_ready;

    // Zero-extend to W+1 so the subtraction is exact.
    assign e_new = {1'b0, setpoint} - {1'b0, feedback};

    // Sign-extended full-width differences; widths chosen so
    // none of these can overflow for any pair of W-bit inputs.
    assign d1_next = {s1_e[W], s1_e} - {e1[W], e1};
    assign d2_next = {{2{s1_e[W]}}, s1_e}
                   - {e1[W], e1, 1'b0}
                   + {{2{e2[W]}}, e2};

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid <= 1'b0;
            s1_e     <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_e     <= e_new;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            out_valid <= 1'b0;
            e0        <= '0;
            d1        <= '0;
            d2        <= '0;
            primed    <= 1'b0;
            e1        <= '0;
            e2        <= '0;
            hist_cnt  <= '0;
        end else if (adv) begin
            out_valid <= 1'b1;
            e0        <= s1_e;
            d1        <= d1_next;
            d2        <= d2_next;
            // Both history taps are real once two samples preceded this one.
            primed    <= (hist_cnt == 2'd2);
            e2        <= e1;
            e1        <= s1_e;
            if (hist_cnt != 2'd2)
                hist_cnt <= hist_cnt + 2'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pid_err_diff.sv
// Scoreboard bench for pid_err_diff.
// Directed vectors, expected terms pushed on input acceptance.
module tb_pid_err_diff;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   setpoint = '0;
    logic [W-1:0]   feedback = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W:0]     e0;
    logic [W+1:0]   d1;
    logic [W+2:0]   d2;
    logic           primed;

    typedef struct {
        int e0;
        int d1;
        int d2;
        bit pr;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    pid_err_diff #(.W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .setpoint(setpoint),
        .feedback(feedback),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .e0(e0),
        .d1(d1),
        .d2(d2),
        .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: output transfers are popped and compared mid-cycle.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            exp_t x;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: e0=%0d", $signed(e0));
            end else begin
                x = q.pop_front();
                chk("e0", int'($signed(e0)), x.e0);
                chk("d1", int'($signed(d1)), x.d1);
                chk("d2", int'($signed(d2)), x.d2);
                chk("primed", int'(primed), int'(x.pr));
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input int sp, input int fb, input bit push,
                        input int xe0, input int xd1, input int xd2,
                        input bit xpr, output int tries);
        bit acc;
        exp_t x;
        in_valid = 1'b1;
        setpoint = W'(sp);
        feedback = W'(fb);
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=0 expected 1");
        end else if (push) begin
            x.e0 = xe0;
            x.d1 = xd1;
            x.d2 = xd2;
            x.pr = xpr;
            q.push_back(x);
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        @(negedge clk);
        chk({name, "_out_valid"}, int'(out_valid), 0);
        chk({name, "_primed"}, int'(primed), 0);
        chk({name, "_e0"}, int'(e0), 0);
        chk({name, "_d1"}, int'(d1), 0);
        chk({name, "_d2"}, int'(d2), 0);
    endtask

    task automatic seq1();
        int t;
        send(1000, 400, 1, 600, 600, 600, 0, t);
        chk("t1_rate_a", t, 1);
        send(1000, 700, 1, 300, -300, -900, 0, t);
        chk("t1_rate_b", t, 1);
        send(1000, 1000, 1, 0, -300, 0, 1, t);
        chk("t1_rate_c", t, 1);
        cycles(3);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
    endtask

    initial begin
        int t;
        int n;

        // Reset state
        cycles(2);
        chk_idle("reset");
        chk("reset_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: basic sequence, one per clock
        seq1();

        // 2: extreme operands, no wrap
        pulse_clr();
        send(0, 65535, 1, -65535, -65535, -65535, 0, t);
        send(65535, 0, 1, 65535, 131070, 196605, 0, t);
        cycles(3);

        // 3 + 4: backpressure, stall holds outputs and history
        pulse_clr();
        out_ready = 1'b0;
        send(10, 0, 1, 10, 10, 10, 0, t);
        chk("t3_accept_a", t, 1);
        send(30, 0, 1, 30, 20, 10, 0, t);
        chk("t3_accept_b", t, 1);
        in_valid = 1'b1;
        setpoint = W'(5);
        feedback = W'(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", int'(in_ready), 0);
            chk("t4_hold_valid", int'(out_valid), 1);
            chk("t4_hold_e0", int'($signed(e0)), 10);
            chk("t4_hold_d1", int'($signed(d1)), 10);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(5, 20, 1, -15, -45, -65, 1, t);
        chk("t3_accept_c", t, 1);
        cycles(4);

        // 5: clear with two samples pending
        out_ready = 1'b0;
        send(100, 0, 0, 0, 0, 0, 0, t);
        send(200, 0, 0, 0, 0, 0, 0, t);
        clr = 1'b1;
        @(negedge clk);
        chk("t5_clr_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_primed", int'(primed), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(50, 20, 1, 30, 30, 30, 0, t);
        cycles(3);

        // 6: reset mid-stream
        out_ready = 1'b0;
        send(7, 1, 0, 0, 0, 0, 0, t);
        send(9, 1, 0, 0, 0, 0, 0, t);
        rst_n = 1'b0;
        in_valid = 1'b1;
        cycles(1);
        chk_idle("t6");
        chk("t6_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seq1();

        // Drain and confirm nothing left outstanding
        n = 0;
        while (q.size() != 0 && n < 50) begin
            cycles(1);
            n++;
        end
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
